irq_ctrl: RTL and testbench

- Parametrised podule interrupt controller. Successor to the fixed-source IRQ/FIQ combiner.
- Takes NUM_SRC asynchronous interrupt sources (Econet, Ethernet, IDE, UART, and others).
- Each source has programmable polarity, edge or level mode, and independent IRQ and FIQ masks.
- Registers are exposed through an 8-bit IOC-style strobe bus. The block drives the registered podule irq and fiq lines.

---
 rtl/irq_ctrl_pkg.sv | 19 +
 rtl/irq_sync.sv | 28 ++
 rtl/irq_ctrl.sv | 154 +++++++++++++++
 tb/tb_irq_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_ctrl_pkg.sv
// Shared register map and bank geometry for the podule interrupt controller.
// Latency: n/a (constants only). Backpressure: n/a.
package irq_ctrl_pkg;

    localparam logic [2:0] REG_STATUS   = 3'd0;
    localparam logic [2:0] REG_RAW      = 3'd1;
    localparam logic [2:0] REG_IRQ_MASK = 3'd2;
    localparam logic [2:0] REG_FIQ_MASK = 3'd3;
    localparam logic [2:0] REG_MODE     = 3'd4;
    localparam logic [2:0] REG_POLARITY = 3'd5;
    localparam logic [2:0] REG_VECTOR   = 3'd6;

    localparam int BANK_BITS = 8;

    function automatic int bank_count(input int num_src);
        return (num_src + BANK_BITS - 1) / BANK_BITS;
    endfunction

endpackage

// File: rtl/irq_sync.sv
// Multi-bit flop-chain synchroniser for asynchronous inputs, reset to 0.
// Latency: STAGES clk edges. Backpressure: none, samples every cycle.
module irq_sync #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] stg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg <= '0;
        end else begin
            stg[0] <= d;
            for (int k = 1; k < STAGES; k++) begin
                stg[k] <= stg[k-1];
            end
        end
    end

    assign q = stg[STAGES-1];

endmodule

// File: rtl/irq_ctrl.sv
// Podule interrupt controller: per-source polarity, edge/level mode, IRQ/FIQ masks; optional vector via IRQ_CTRL_VECTOR_EN.
// Latency: level src -> irq SYNC_STAGES+1 edges, edge src -> SYNC_STAGES+2; writes commit 1 edge after the synced strobe falls.
// Backpressure: none; strobes shorter than one clk may be dropped, reads are combinational and side-effect free.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int NUM_SRC     = 8,
    parameter int ADDR_W      = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src,
    input  logic               cs,
    input  logic               rd,
    input  logic               wr,
    input  logic [ADDR_W-1:0]  addr,
    input  logic [7:0]         wdata,
    output logic [7:0]         rdata,
    output logic               rdata_oe,
    output logic               irq,
    output logic               fiq
);

    localparam int NB     = bank_count(NUM_SRC);
    localparam int PAD    = NB * BANK_BITS;
    localparam int BANK_W = ADDR_W - 3;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        dat;
    } wr_cap_t;

    logic [NUM_SRC-1:0] src_sync, s, s_d, rise, edge_lat, pend;
    logic [NUM_SRC-1:0] im, fm, mode, pol;
    logic [NUM_SRC-1:0] bank_hit, wbits, wr_im, wr_fm, wr_mode, wr_pol, w1c, mode_next;
    logic               ws, ws_d, commit;
    wr_cap_t            cap;
    logic [2:0]         cap_reg;
    logic [BANK_W-1:0]  cap_bank, rd_bank;

    irq_sync #(.WIDTH(NUM_SRC), .STAGES(SYNC_STAGES)) u_src_sync (
        .clk (clk),
        .rst (rst),
        .d   (src),
        .q   (src_sync)
    );

    irq_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_wr_sync (
        .clk (clk),
        .rst (rst),
        .d   (cs & wr),
        .q   (ws)
    );

    assign s      = src_sync ^ pol;
    assign rise   = s & ~s_d;
    assign pend   = (mode & edge_lat) | (~mode & s);
    assign commit = ws_d & ~ws;

    assign cap_reg  = cap.addr[2:0];
    assign cap_bank = cap.addr[ADDR_W-1:3];

    // Map the committed byte onto the source bits of the addressed bank.
    always_comb begin
        bank_hit = '0;
        wbits    = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            bank_hit[i] = commit && (int'(cap_bank) == i / BANK_BITS);
            wbits[i]    = cap.dat[i % BANK_BITS];
        end
    end

    assign wr_im     = bank_hit & {NUM_SRC{cap_reg == REG_IRQ_MASK}};
    assign wr_fm     = bank_hit & {NUM_SRC{cap_reg == REG_FIQ_MASK}};
    assign wr_mode   = bank_hit & {NUM_SRC{cap_reg == REG_MODE}};
    assign wr_pol    = bank_hit & {NUM_SRC{cap_reg == REG_POLARITY}};
    assign w1c       = bank_hit & wbits & mode & {NUM_SRC{cap_reg == REG_STATUS}};
    assign mode_next = (mode & ~wr_mode) | (wbits & wr_mode);

`ifdef IRQ_CTRL_VECTOR_EN
    logic [7:0]         vec_q, vec_next;
    logic [NUM_SRC-1:0] vec_src;

    always_comb begin
        vec_src  = pend & (im | fm);
        vec_next = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (vec_src[i]) vec_next = {1'b1, 2'b00, 5'(i)};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) vec_q <= '0;
        else     vec_q <= vec_next;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_d      <= '0;
            ws_d     <= 1'b0;
            cap      <= '0;
            im       <= '0;
            fm       <= '0;
            mode     <= '0;
            pol      <= '0;
            edge_lat <= '0;
            irq      <= 1'b0;
            fiq      <= 1'b0;
        end else begin
            s_d  <= s;
            ws_d <= ws;
            if (ws) begin
                cap.addr <= addr;
                cap.dat  <= wdata;
            end
            im   <= (im  & ~wr_im)  | (wbits & wr_im);
            fm   <= (fm  & ~wr_fm)  | (wbits & wr_fm);
            pol  <= (pol & ~wr_pol) | (wbits & wr_pol);
            mode <= mode_next;
            // A latch only lives in edge mode; a fresh rise beats a same-cycle W1C.
            edge_lat <= ((edge_lat & ~w1c) | rise) & mode & mode_next;
            irq <= |(pend & im);
            fiq <= |(pend & fm);
        end
    end

    assign rdata_oe = cs & rd;
    assign rd_bank  = addr[ADDR_W-1:3];

    function automatic logic [7:0] bank_slice(input logic [PAD-1:0] v, input int b);
        return v[b*BANK_BITS +: BANK_BITS];
    endfunction

    always_comb begin
        rdata = '0;
        if (rdata_oe && int'(rd_bank) < NB) begin
            case (addr[2:0])
                REG_STATUS:   rdata = bank_slice(PAD'(pend), int'(rd_bank));
                REG_RAW:      rdata = bank_slice(PAD'(s), int'(rd_bank));
                REG_IRQ_MASK: rdata = bank_slice(PAD'(im), int'(rd_bank));
                REG_FIQ_MASK: rdata = bank_slice(PAD'(fm), int'(rd_bank));
                REG_MODE:     rdata = bank_slice(PAD'(mode), int'(rd_bank));
                REG_POLARITY: rdata = bank_slice(PAD'(pol), int'(rd_bank));
`ifdef IRQ_CTRL_VECTOR_EN
                REG_VECTOR:   rdata = (rd_bank == '0) ? vec_q : 8'h00;
`endif
                default:      rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl (NUM_SRC=12): directed latency/W1C/bank checks plus random traffic vs a behavioural model.
module tb_irq_ctrl;

    localparam int NSRC = 12;
    localparam int AW   = 5;
    localparam int SS   = 2;
    localparam int NB   = (NSRC + 7) / 8;
    localparam logic [31:0] VM = (32'd1 << NSRC) - 32'd1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NSRC-1:0] src = '0;
    logic            cs = 1'b0, rd = 1'b0, wr = 1'b0;
    logic [AW-1:0]   addr = '0;
    logic [7:0]      wdata = '0;
    logic [7:0]      rdata;
    logic            rdata_oe, irq, fiq;
    logic            chk_en = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    irq_ctrl #(.NUM_SRC(NSRC), .ADDR_W(AW), .SYNC_STAGES(SS)) dut (
        .clk      (clk),
        .rst      (rst),
        .src      (src),
        .cs       (cs),
        .rd       (rd),
        .wr       (wr),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .rdata_oe (rdata_oe),
        .irq      (irq),
        .fiq      (fiq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: registers as flat 32-bit vectors, src/strobe history as shift arrays.
    logic [31:0] h [SS];
    logic        wh [SS];
    logic [31:0] s_prev = '0, lat = '0, im = '0, fm = '0, md = '0, pl = '0;
    logic        ws_prev = 1'b0, m_irq = 1'b0, m_fiq = 1'b0;
    logic [AW-1:0] cap_a = '0;
    logic [7:0]  cap_d = '0, m_vec = '0;

    always @(posedge clk or posedge rst) begin : model
        logic [31:0] s, pend, rise, act, wmask, wbits, w1c, mnew;
        logic        ws, commit;
        int          b, r;
        if (rst) begin
            for (int k = 0; k < SS; k++) begin h[k] = '0; wh[k] = 1'b0; end
            s_prev = '0; lat = '0; im = '0; fm = '0; md = '0; pl = '0;
            ws_prev = 1'b0; m_irq = 1'b0; m_fiq = 1'b0; cap_a = '0; cap_d = '0; m_vec = '0;
        end else begin
            s    = h[SS-1] ^ pl;
            pend = (md & lat) | (~md & s);
            rise = s & ~s_prev;
            m_irq = |(pend & im);
            m_fiq = |(pend & fm);
            act   = pend & (im | fm);
            m_vec = 8'h00;
            for (int i = NSRC - 1; i >= 0; i--) if (act[i]) m_vec = 8'h80 | 8'(i);
            ws     = wh[SS-1];
            commit = ws_prev && !ws;
            b = int'(cap_a) >> 3;
            r = int'(cap_a) & 7;
            wmask = (commit && b < NB) ? ((32'hFF << (8 * b)) & VM) : 32'h0;
            wbits = 32'(cap_d) << (8 * b);
            w1c   = (r == 0) ? (wbits & wmask & md) : 32'h0;
            mnew  = (r == 4) ? ((md & ~wmask) | (wbits & wmask)) : md;
            lat   = ((lat & ~w1c) | (rise & md)) & mnew;
            if (r == 2) im = (im & ~wmask) | (wbits & wmask);
            if (r == 3) fm = (fm & ~wmask) | (wbits & wmask);
            if (r == 5) pl = (pl & ~wmask) | (wbits & wmask);
            md = mnew;
            if (ws) begin cap_a = addr; cap_d = wdata; end
            for (int k = SS - 1; k > 0; k--) begin h[k] = h[k-1]; wh[k] = wh[k-1]; end
            h[0]  = 32'(src) & VM;
            wh[0] = cs & wr;
            s_prev  = s;
            ws_prev = ws;
        end
    end

    function automatic logic [7:0] exp_read(input logic [AW-1:0] a);
        int b = int'(a) >> 3;
        int r = int'(a) & 7;
        logic [31:0] s = h[SS-1] ^ pl;
        logic [31:0] v;
        if (b >= NB) return 8'h00;
        case (r)
            0: v = (md & lat) | (~md & s);
            1: v = s;
            2: v = im;
            3: v = fm;
            4: v = md;
            5: v = pl;
`ifdef IRQ_CTRL_VECTOR_EN
            6: return (b == 0) ? m_vec : 8'h00;
`endif
            default: return 8'h00;
        endcase
        return 8'(v >> (8 * b));
    endfunction

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("irq_cycle", irq, m_irq);
            check("fiq_cycle", fiq, m_fiq);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [AW-1:0] a, output logic [7:0] d);
        cs = 1'b1; rd = 1'b1; addr = a;
        #1 d = rdata;
        cs = 1'b0; rd = 1'b0;
    endtask

    task automatic rd_check(input string name, input logic [AW-1:0] a, input logic [7:0] exp);
        logic [7:0] d;
        do_read(a, d);
        check(name, d, exp);
    endtask

    task automatic wr_start(input logic [AW-1:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        cs = 1'b1; wr = 1'b1; addr = a; wdata = d;
        step(2);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [7:0] d);
        wr_start(a, d);
        cs = 1'b0; wr = 1'b0;
        step(4);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        step(3);
        rst = 1'b0;
        step(1);
        chk_en = 1'b1;

        // Reset state: every register of banks 0..3 reads 0; rdata_oe follows cs&rd only.
        for (int a = 0; a < 32; a++) rd_check("reset_read", AW'(a), 8'h00);
        check("reset_irq", irq, 1'b0);
        check("reset_fiq", fiq, 1'b0);
        for (int c = 0; c < 2; c++) begin
            for (int r = 0; r < 2; r++) begin
                cs = c[0]; rd = r[0];
                #1 check("rdata_oe", rdata_oe, c[0] & r[0]);
                if (!r[0]) check("rdata_idle", rdata, 8'h00);
            end
        end
        cs = 1'b0; rd = 1'b0;

        // Level source latency.
        do_write(5'd2, 8'h01);
        src[0] = 1'b1;
        step(2); check("lvl_irq_e2", irq, 1'b0);
        step(1); check("lvl_irq_e3", irq, 1'b1);
        rd_check("lvl_status", 5'd0, 8'h01);
        src[0] = 1'b0;
        step(2); check("lvl_drop_e2", irq, 1'b1);
        step(1); check("lvl_drop_e3", irq, 1'b0);

        // Edge source, W1C, and set-wins collision.
        do_write(5'd4, 8'h02);
        do_write(5'd3, 8'h02);
        src[1] = 1'b1; step(1); src[1] = 1'b0;
        step(2); rd_check("edge_status_e3", 5'd0, 8'h02);
        check("edge_fiq_e3", fiq, 1'b0);
        step(1); check("edge_fiq_e4", fiq, 1'b1);
        step(3); check("edge_fiq_held", fiq, 1'b1);
        do_write(5'd0, 8'h02);
        check("w1c_fiq", fiq, 1'b0);
        rd_check("w1c_status", 5'd0, 8'h00);
        src[1] = 1'b1; step(1); src[1] = 1'b0;
        step(4); check("edge2_fiq", fiq, 1'b1);
        wr_start(5'd0, 8'h02);
        cs = 1'b0; wr = 1'b0; src[1] = 1'b1;
        step(1); src[1] = 1'b0;
        step(4);
        rd_check("collide_status", 5'd0, 8'h02);
        check("collide_fiq", fiq, 1'b1);
        do_write(5'd0, 8'h02);
        rd_check("collide_clear", 5'd0, 8'h00);
        do_write(5'd4, 8'h00);
        do_write(5'd3, 8'h00);

        // Active-low source, W1C ignored in level mode.
        do_write(5'd5, 8'h04);
        do_write(5'd2, 8'h04);
        step(1); check("pol_irq", irq, 1'b1);
        rd_check("pol_status", 5'd0, 8'h04);
        do_write(5'd0, 8'h04);
        rd_check("lvl_w1c_status", 5'd0, 8'h04);
        check("lvl_w1c_irq", irq, 1'b1);
        do_write(5'd2, 8'h00);
        check("mask_off_irq", irq, 1'b0);
        do_write(5'd5, 8'h00);

        // Partial bank 1 and absent bank 2.
        do_write(5'd10, 8'hFF);
        rd_check("bank1_mask", 5'd10, 8'h0F);
        do_write(5'd18, 8'hFF);
        rd_check("bank2_mask", 5'd18, 8'h00);
        src[11] = 1'b1;
        step(4); check("src11_irq", irq, 1'b1);
        rd_check("bank1_status", 5'd8, 8'h08);
        src[11] = 1'b0;
        do_write(5'd10, 8'h00);

        // Vector register.
        do_write(5'd2, 8'hFF);
        src[5] = 1'b1; src[3] = 1'b1;
        step(5);
`ifdef IRQ_CTRL_VECTOR_EN
        rd_check("vector_a", 5'd6, 8'h83);
        rd_check("vector_bank1", 5'd14, 8'h00);
        src[3] = 1'b0; step(5);
        rd_check("vector_b", 5'd6, 8'h85);
`else
        rd_check("vector_off", 5'd6, 8'h00);
`endif
        src = '0;
        do_write(5'd2, 8'h00);

        // Random traffic against the model.
        for (int it = 0; it < 500; it++) begin
            case ($urandom_range(0, 3))
                0: begin src = src ^ NSRC'($urandom & VM); step(1); end
                1: do_write(AW'($urandom_range(0, 31)), 8'($urandom));
                2: begin
                    addr = AW'($urandom_range(0, 31));
                    do_read(addr, d);
                    check("rand_read", d, exp_read(addr));
                    step(1);
                end
                default: step($urandom_range(1, 4));
            endcase
        end

        step(2);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
